n64_vinfo_detect: RTL and testbench
===================================

// Module: n64_vinfo_detect
// PURPOSE
//  Front-end stage ahead of the video demux. It watches the raw N64 video bus
//  (nDSYNC plus the 7-bit D bus) and generates the color phase counter data_cnt.
//  It also detects PAL/NTSC, detects 240p vs 480i, and decides whether deblur is
//  required. Its packed output feeds the demux parameter input
//  {data_cnt, vmode, ndo_deblur, n15bit_mode} directly.
// PARAMETERS
//  LINE_CNT_W       10     width of the per-field line counter (saturating)
//  PAL_LINE_THRESH  290    a field with line count >= this is PAL (vmode=1)
//  DEBLUR_STABLE    4      consecutive agreeing frames required to change ndo_deblur
// PORTS
//  VCLK            in   1   video clock
//  nRST            in   1   synchronous reset, active-low
//  nDSYNC          in   1   low = sync byte on D_i, high = color byte
//  D_i             in   7   N64 data bus; sync byte: [3]nVSYNC [2]nCLAMP [1]nHSYNC [0]nCSYNC
//  n15bit_mode_i   in   1   passed through to demuxparams_o[0]
//  deblur_mode_i   in   2   00 auto, 01 force deblur on, 1x force deblur off
//  demuxparams_o   out  5   {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode_i}
//  n64_480i_o      out  1   1 = interlaced content detected
//  field_lines_o   out  LINE_CNT_W  line count of the last completed field
// BEHAVIOUR
//  Reset values: data_cnt=0, vmode=0 (NTSC), ndo_deblur=1, n64_480i=0, field_lines=0.
//    All internal counters and flags are also 0, except sync_prev=4'hF.
//  Reset is synchronous and can occur at any point, including mid-frame. The first
//    post-reset vsync edge starts a fresh field and produces no decision.
//  data_cnt: !nDSYNC -> 2'b01; else data_cnt+1 (wraps 11->00). It is registered, so
//    the value is 01/10/11 in the cycles where R/G/B bytes appear.
//  Sync sampling happens only when !nDSYNC: sync_cur <= D_i[3:0], and sync_prev holds
//    the previous sample. Edges are detected between consecutive samples only.
//  Line counter counts each nHSYNC falling edge and saturates at 2^LINE_CNT_W-1.
//  Field end = nVSYNC falling edge. In that same cycle:
//    - field_lines <= line_cnt (the pre-edge value).
//    - vmode <= (line_cnt >= PAL_LINE_THRESH).
//    - line_cnt <= 0. An nHSYNC edge in the same sample is ignored.
//    - FrameID <= sampled nHSYNC; n64_480i <= (FrameID != FrameID_prev).
//    - vmode, n64_480i and field_lines change only at field end.
//  Pixel phase toggles on each sync byte and is reset to 0 by a rising edge of nCSYNC.
//    Pixel zero flag = OR of the three color bytes == 0, evaluated after data_cnt=11.
//  ndo_deblur selection:
//    - deblur_mode_i=01 -> 0, 1x -> 1; the change is applied at the next field end.
//    - n64_480i=1 forces ndo_deblur=1 regardless of mode.
// CONFIGURATION
//  Macro AUTO_DEBLUR_EN.
//  Defined: auto mode (00) runs the detector over active pixels only
//    (nVSYNC & nHSYNC & nCLAMP high).
//    - odd_blank: starts at 1 each frame; cleared by any phase-1 nonzero pixel.
//    - even_seen: set by any phase-0 nonzero pixel.
//    - At field end, det = odd_blank & even_seen.
//    - If det differs from the current ~ndo_deblur, a stability counter increments;
//      otherwise it clears.
//    - When the counter reaches DEBLUR_STABLE, ndo_deblur <= ~det and the counter clears.
//  Not defined: detector logic is absent; auto mode behaves as force-off (ndo_deblur=1).
// TESTING
//  1 Sync byte then 3 color bytes, repeated -> data_cnt 01,10,11 on color cycles;
//    01 after every sync byte.
//  2 Fields of 263 then 262 lines -> field_lines 263/262, vmode=0.
//    Fields of 313 lines -> vmode=1 at the first field end.
//  3 nHSYNC alternates 0/1 at successive nVSYNC falls -> n64_480i=1 from the 2nd field
//    end; constant nHSYNC -> n64_480i=0.
//  4 AUTO_DEBLUR_EN, mode 00, 240p, odd pixels 0 and even pixels 0x55 -> ndo_deblur
//    stays 1 through frame 3 and goes to 0 at the 4th field end. One full-color frame
//    then does not revert the output.
//  5 nRST low for 1 cycle mid-field with 200 lines counted -> all outputs return to reset
//    values. The next field end reports only lines counted after reset.
//  6 LINE_CNT_W=4 with 20 lines in a field -> field_lines=15 (saturated), vmode=0.

Source files
------------

// File: rtl/n64_vinfo_detect.sv
// N64 video front-end: colour phase counter, PAL/NTSC, 240p/480i and deblur decision.
// Optional auto-deblur detector is built when AUTO_DEBLUR_EN is defined.
module n64_vinfo_detect #(
   parameter int unsigned LINE_CNT_W      = 10,
   parameter int unsigned PAL_LINE_THRESH = 290,
   parameter int unsigned DEBLUR_STABLE   = 4
) (
   input  logic                  VCLK,
   input  logic                  nRST,
   input  logic                  nDSYNC,
   input  logic [6:0]            D_i,
   input  logic                  n15bit_mode_i,
   input  logic [1:0]            deblur_mode_i,
   output logic [4:0]            demuxparams_o,
   output logic                  n64_480i_o,
   output logic [LINE_CNT_W-1:0] field_lines_o
);

   logic [1:0]            data_cnt;
   logic [3:0]            sync_cur;
   logic [3:0]            sync_prev;
   logic                  new_sample;
   logic [LINE_CNT_W-1:0] line_cnt;
   logic [LINE_CNT_W-1:0] field_lines;
   logic                  vmode;
   logic                  ndo_deblur;
   logic                  n64_480i;
   logic                  frame_id;
   logic                  field_started;

   logic vs_fall;
   logic hs_fall;
   logic field_end;
   logic frame_flip;
   logic unused;

   // Edges are evaluated the cycle after a sync byte, between the two latest samples.
   assign vs_fall    = sync_prev[3] & ~sync_cur[3];
   assign hs_fall    = sync_prev[1] & ~sync_cur[1];
   assign field_end  = new_sample & vs_fall;
   assign frame_flip = sync_cur[1] ^ frame_id;

`ifdef AUTO_DEBLUR_EN
   localparam int unsigned STAB_W = $clog2(DEBLUR_STABLE + 1);

   logic [6:0]        color_acc;
   logic              pix_phase;
   logic              odd_blank;
   logic              even_seen;
   logic [STAB_W-1:0] stable_cnt;
   logic              cs_rise;
   logic              pix_nz;
   logic              pix_active;
   logic              det;

   assign cs_rise    = ~sync_prev[0] & sync_cur[0];
   assign pix_nz     = (color_acc | D_i) != 7'd0;
   assign pix_active = &sync_cur[3:1];
   assign det        = odd_blank & even_seen;
   assign unused     = sync_prev[2];
`else
   assign unused = ^{D_i[6:4], sync_cur[2], sync_cur[0], sync_prev[2], sync_prev[0],
                     DEBLUR_STABLE[0]};
`endif

   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         data_cnt      <= 2'b00;
         sync_cur      <= 4'h0;
         sync_prev     <= 4'hF;
         new_sample    <= 1'b0;
         line_cnt      <= '0;
         field_lines   <= '0;
         vmode         <= 1'b0;
         ndo_deblur    <= 1'b1;
         n64_480i      <= 1'b0;
         frame_id      <= 1'b0;
         field_started <= 1'b0;
`ifdef AUTO_DEBLUR_EN
         color_acc     <= 7'd0;
         pix_phase     <= 1'b0;
         odd_blank     <= 1'b0;
         even_seen     <= 1'b0;
         stable_cnt    <= '0;
`endif
      end else begin
         data_cnt   <= nDSYNC ? data_cnt + 2'd1 : 2'b01;
         new_sample <= ~nDSYNC;
         if (!nDSYNC) begin
            sync_prev <= sync_cur;
            sync_cur  <= D_i[3:0];
         end

`ifdef AUTO_DEBLUR_EN
         if (new_sample) begin
            pix_phase <= cs_rise ? 1'b0 : ~pix_phase;
         end
         if (nDSYNC) begin
            color_acc <= (data_cnt == 2'b01) ? D_i : (color_acc | D_i);
            // Third colour byte completes the pixel.
            if (data_cnt == 2'b11 && pix_active && pix_nz) begin
               if (pix_phase) begin
                  odd_blank <= 1'b0;
               end else begin
                  even_seen <= 1'b1;
               end
            end
         end
`endif

         if (field_end) begin
            line_cnt      <= '0;
            frame_id      <= sync_cur[1];
            field_started <= 1'b1;
`ifdef AUTO_DEBLUR_EN
            odd_blank     <= 1'b1;
            even_seen     <= 1'b0;
`endif
            // The first field end after reset only opens a field.
            if (field_started) begin
               field_lines <= line_cnt;
               vmode       <= 32'(line_cnt) >= PAL_LINE_THRESH;
               n64_480i    <= frame_flip;
`ifdef AUTO_DEBLUR_EN
               stable_cnt  <= '0;
`endif
               if (frame_flip || deblur_mode_i[1]) begin
                  ndo_deblur <= 1'b1;
               end else if (deblur_mode_i[0]) begin
                  ndo_deblur <= 1'b0;
               end else begin
`ifdef AUTO_DEBLUR_EN
                  // det disagrees with current state when det == ndo_deblur.
                  if (det == ndo_deblur) begin
                     if (32'(stable_cnt) + 32'd1 >= DEBLUR_STABLE) begin
                        ndo_deblur <= ~det;
                     end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                     end
                  end
`else
                  ndo_deblur <= 1'b1;
`endif
               end
            end
         end else if (new_sample && hs_fall && line_cnt != {LINE_CNT_W{1'b1}}) begin
            line_cnt <= line_cnt + 1'b1;
         end
      end
   end

   assign demuxparams_o = {data_cnt, vmode, ndo_deblur, n15bit_mode_i};
   assign n64_480i_o    = n64_480i;
   assign field_lines_o = field_lines;

endmodule

// File: tb/tb_n64_vinfo_detect.sv
// Directed bench for n64_vinfo_detect; a second instance uses LINE_CNT_W=4 for saturation.
module tb_n64_vinfo_detect;

   logic       VCLK = 1'b0;
   logic       nRST = 1'b0;
   logic       nDSYNC = 1'b1;
   logic [6:0] D_i = 7'd0;
   logic       n15bit_mode_i = 1'b0;
   logic [1:0] deblur_mode_i = 2'b10;

   logic [4:0] dp;
   logic       i480;
   logic [9:0] fl;
   logic [4:0] dp4;
   logic       i480_4;
   logic [3:0] fl4;

   int checks = 0;
   int errors = 0;

   n64_vinfo_detect dut (
      .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
      .n15bit_mode_i(n15bit_mode_i), .deblur_mode_i(deblur_mode_i),
      .demuxparams_o(dp), .n64_480i_o(i480), .field_lines_o(fl)
   );

   n64_vinfo_detect #(.LINE_CNT_W(4)) dut_w4 (
      .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
      .n15bit_mode_i(n15bit_mode_i), .deblur_mode_i(deblur_mode_i),
      .demuxparams_o(dp4), .n64_480i_o(i480_4), .field_lines_o(fl4)
   );

   always #5 VCLK = ~VCLK;

   task automatic tick(input logic ds, input logic [6:0] d);
      nDSYNC = ds;
      D_i    = d;
      @(posedge VCLK);
      #1;
   endtask

   task automatic pixel(input logic [3:0] s, input logic [6:0] c);
      tick(1'b0, {3'b000, s});
      tick(1'b1, c);
      tick(1'b1, c);
      tick(1'b1, c);
   endtask

   // One line: an hsync/csync-low pixel, then two even/odd pixel pairs.
   task automatic lines(input int n, input logic [6:0] ev, input logic [6:0] od);
      for (int i = 0; i < n; i++) begin
         pixel(4'b1100, 7'd0);
         pixel(4'b1111, ev);
         pixel(4'b1111, od);
         pixel(4'b1111, ev);
         pixel(4'b1111, od);
      end
   endtask

   task automatic vsync(input logic hs);
      pixel({1'b0, 1'b1, hs, 1'b1}, 7'd0);
      pixel(4'hF, 7'd0);
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      tick(1'b1, 7'd0);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dp !== 5'b00010) begin
         errors++;
         $display("FAIL reset_params: got %b want 00010", dp);
      end
      checks++;
      if (i480 !== 1'b0 || fl !== 10'd0) begin
         errors++;
         $display("FAIL reset_480i_lines: got %b/%0d want 0/0", i480, fl);
      end
   endtask

   task automatic test_data_cnt();
      logic       ds_seq [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] cnt_exp[8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
      n15bit_mode_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(ds_seq[i], 7'h0F);
         checks++;
         if (dp[4:3] !== cnt_exp[i]) begin
            errors++;
            $display("FAIL data_cnt[%0d]: got %0d want %0d", i, dp[4:3], cnt_exp[i]);
         end
      end
      checks++;
      if (dp[0] !== 1'b1) begin
         errors++;
         $display("FAIL n15bit_pass1: got %b want 1", dp[0]);
      end
      n15bit_mode_i = 1'b0;
      tick(1'b1, 7'h0F);
      checks++;
      if (dp[0] !== 1'b0) begin
         errors++;
         $display("FAIL n15bit_pass0: got %b want 0", dp[0]);
      end
   endtask

   task automatic test_field_lines();
      vsync(1'b1);
      checks++;
      if (fl !== 10'd0) begin
         errors++;
         $display("FAIL first_edge_no_decision: got %0d want 0", fl);
      end
      lines(263, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl !== 10'd263 || dp[2] !== 1'b0) begin
         errors++;
         $display("FAIL ntsc_263: got %0d vmode %b want 263 vmode 0", fl, dp[2]);
      end
      lines(262, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl !== 10'd262 || dp[2] !== 1'b0) begin
         errors++;
         $display("FAIL ntsc_262: got %0d vmode %b want 262 vmode 0", fl, dp[2]);
      end
      lines(313, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl !== 10'd313 || dp[2] !== 1'b1) begin
         errors++;
         $display("FAIL pal_313: got %0d vmode %b want 313 vmode 1", fl, dp[2]);
      end
      checks++;
      if (i480 !== 1'b0) begin
         errors++;
         $display("FAIL progressive_480i: got %b want 0", i480);
      end
   endtask

   task automatic test_mid_reset();
      lines(200, 7'd0, 7'd0);
      do_reset();
      checks++;
      if (dp !== 5'b00010 || i480 !== 1'b0 || fl !== 10'd0) begin
         errors++;
         $display("FAIL mid_reset: got %b/%b/%0d want 00010/0/0", dp, i480, fl);
      end
      lines(30, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl !== 10'd0 || dp[2] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_first_edge: got %0d vmode %b want 0 vmode 0", fl, dp[2]);
      end
      lines(100, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl !== 10'd100) begin
         errors++;
         $display("FAIL mid_reset_count: got %0d want 100", fl);
      end
   endtask

   task automatic test_interlace();
      do_reset();
      deblur_mode_i = 2'b01;
      pixel(4'hF, 7'd0);
      vsync(1'b0);
      lines(5, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (i480 !== 1'b1 || dp[1] !== 1'b1) begin
         errors++;
         $display("FAIL 480i_first: got 480i %b ndo %b want 1 1", i480, dp[1]);
      end
      lines(5, 7'd0, 7'd0);
      vsync(1'b0);
      checks++;
      if (i480 !== 1'b1) begin
         errors++;
         $display("FAIL 480i_second: got %b want 1", i480);
      end
      lines(5, 7'd0, 7'd0);
      vsync(1'b0);
      checks++;
      if (i480 !== 1'b0 || dp[1] !== 1'b0) begin
         errors++;
         $display("FAIL 480i_constant: got 480i %b ndo %b want 0 0", i480, dp[1]);
      end
   endtask

   task automatic test_deblur_mode();
      do_reset();
      deblur_mode_i = 2'b01;
      pixel(4'hF, 7'd0);
      vsync(1'b1);
      checks++;
      if (dp[1] !== 1'b1) begin
         errors++;
         $display("FAIL force_on_first_edge: got %b want 1", dp[1]);
      end
      lines(2, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (dp[1] !== 1'b0) begin
         errors++;
         $display("FAIL force_on: got %b want 0", dp[1]);
      end
      deblur_mode_i = 2'b11;
      lines(2, 7'd0, 7'd0);
      checks++;
      if (dp[1] !== 1'b0) begin
         errors++;
         $display("FAIL force_off_waits: got %b want 0", dp[1]);
      end
      vsync(1'b1);
      checks++;
      if (dp[1] !== 1'b1) begin
         errors++;
         $display("FAIL force_off: got %b want 1", dp[1]);
      end
`ifndef AUTO_DEBLUR_EN
      deblur_mode_i = 2'b01;
      vsync(1'b1);
      deblur_mode_i = 2'b00;
      vsync(1'b1);
      checks++;
      if (dp[1] !== 1'b1) begin
         errors++;
         $display("FAIL auto_is_off: got %b want 1", dp[1]);
      end
`endif
   endtask

`ifdef AUTO_DEBLUR_EN
   task automatic test_auto_deblur();
      do_reset();
      deblur_mode_i = 2'b00;
      pixel(4'hF, 7'd0);
      vsync(1'b1);
      for (int f = 1; f <= 4; f++) begin
         lines(4, 7'h55, 7'h00);
         vsync(1'b1);
         checks++;
         if (dp[1] !== (f < 4)) begin
            errors++;
            $display("FAIL auto_frame%0d: got %b want %b", f, dp[1], (f < 4));
         end
      end
      lines(4, 7'h55, 7'h7F);
      vsync(1'b1);
      checks++;
      if (dp[1] !== 1'b0) begin
         errors++;
         $display("FAIL auto_hold: got %b want 0", dp[1]);
      end
   endtask
`endif

   task automatic test_saturate();
      do_reset();
      deblur_mode_i = 2'b10;
      pixel(4'hF, 7'd0);
      vsync(1'b1);
      lines(20, 7'd0, 7'd0);
      vsync(1'b1);
      checks++;
      if (fl4 !== 4'd15 || dp4[2] !== 1'b0) begin
         errors++;
         $display("FAIL saturate_w4: got %0d vmode %b want 15 vmode 0", fl4, dp4[2]);
      end
      checks++;
      if (fl !== 10'd20) begin
         errors++;
         $display("FAIL lines_20: got %0d want 20", fl);
      end
   endtask

   initial begin
      test_reset();
      test_data_cnt();
      test_field_lines();
      test_mid_reset();
      test_interlace();
      test_deblur_mode();
`ifdef AUTO_DEBLUR_EN
      test_auto_deblur();
`endif
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
